// File: rtl/sreg_arbiter_if.sv
// Bundle between the two requesters (execute stage, load/store unit), the
// arbiter, and the scalar register file command port.
//   slave  : the arbiter's view (takes requests, drives the register file)
//   master : the environment's view (requesters plus register file)
interface sreg_arbiter_if #(
    parameter int NREGS_LOG2 = 3,
    parameter int DW         = 16
);
    // requester side
    logic                  ReqA;
    logic                  ReqB;
    logic [1:0]            OpA;
    logic [1:0]            OpB;
    logic [NREGS_LOG2-1:0] AddrA;
    logic [NREGS_LOG2-1:0] AddrB;
    logic [DW-1:0]         WDataA;
    logic [DW-1:0]         WDataB;
    logic                  DoneA;
    logic                  DoneB;
    logic [DW-1:0]         RData;
    logic                  Busy;

    // register file side
    logic [NREGS_LOG2-1:0] SAddr;
    logic [DW-1:0]         SDataIn;
    logic                  SRD;
    logic                  SWR;
    logic                  SWR_l;
    logic                  SWR_h;
    logic [DW-1:0]         SDataOut;

    modport slave (
        input  ReqA, ReqB, OpA, OpB, AddrA, AddrB, WDataA, WDataB, SDataOut,
        output DoneA, DoneB, RData, Busy, SAddr, SDataIn, SRD, SWR, SWR_l, SWR_h
    );

    modport master (
        output ReqA, ReqB, OpA, OpB, AddrA, AddrB, WDataA, WDataB, SDataOut,
        input  DoneA, DoneB, RData, Busy, SAddr, SDataIn, SRD, SWR, SWR_l, SWR_h
    );
endinterface

// File: rtl/sreg_arbiter.sv
// Two-port arbiter / sequencer for the scalar register file.
// Port A = execute stage, port B = load/store unit. One transaction at a time
// is walked through IDLE -> SETUP -> EXEC -> (CAPT) -> DONE; every output is
// a register so the register file sees clean, glitch-free strobes.
// Optional feature: define SREG_ARB_RR_EN for round-robin tie breaking;
// otherwise port A has fixed priority.
module sreg_arbiter #(
    parameter int NREGS_LOG2 = 3,
    parameter int DW         = 16
) (
    input  logic            Clk,
    input  logic            Rst,
    sreg_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_EXEC  = 3'd2,
        S_CAPT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_WRL = 2'b10;
    localparam logic [1:0] OP_WRH = 2'b11;

    state_t                state_q;
    logic [1:0]            op_q;
    logic                  owner_b_q;   // 0 = A owns the transaction, 1 = B
    logic [NREGS_LOG2-1:0] saddr_q;
    logic [DW-1:0]         sdin_q;
    logic [DW-1:0]         rdata_q;
    logic                  srd_q;
    logic                  swr_q;
    logic                  swrl_q;
    logic                  swrh_q;
    logic                  done_a_q;
    logic                  done_b_q;
    logic                  busy_q;

    // Winner selection, only meaningful while in IDLE with a request pending.
    logic pick_b_d;

`ifdef SREG_ARB_RR_EN
    logic last_b_q;     // 1 = B was served last, so A wins the next tie

    // On a tie, the side not served last wins.
    always_comb begin
        pick_b_d = bus.ReqB & (~bus.ReqA | ~last_b_q);
    end

    // Record who was served whenever IDLE hands out a grant.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            last_b_q <= 1'b1;
        end else if (state_q == S_IDLE && (bus.ReqA || bus.ReqB)) begin
            last_b_q <= pick_b_d;
        end
    end
`else
    // Fixed priority: B only gets the port when A is not asking.
    always_comb begin
        pick_b_d = bus.ReqB & ~bus.ReqA;
    end
`endif

    // Main sequencer: state plus all registered outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_RD;
            owner_b_q <= 1'b0;
            saddr_q   <= '0;
            sdin_q    <= '0;
            rdata_q   <= '0;
            srd_q     <= 1'b0;
            swr_q     <= 1'b0;
            swrl_q    <= 1'b0;
            swrh_q    <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            // Strobes and Done are single-cycle pulses; only the state
            // that raises them sets them again.
            srd_q    <= 1'b0;
            swr_q    <= 1'b0;
            swrl_q   <= 1'b0;
            swrh_q   <= 1'b0;
            done_a_q <= 1'b0;
            done_b_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    // Requests are only looked at here; the latched copy is
                    // what the rest of the transaction runs on.
                    if (bus.ReqA || bus.ReqB) begin
                        owner_b_q <= pick_b_d;
                        op_q      <= pick_b_d ? bus.OpB    : bus.OpA;
                        saddr_q   <= pick_b_d ? bus.AddrB  : bus.AddrA;
                        sdin_q    <= pick_b_d ? bus.WDataB : bus.WDataA;
                        busy_q    <= 1'b1;
                        state_q   <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    // Address/data have had a full cycle to settle; fire
                    // exactly one strobe for the EXEC cycle.
                    srd_q   <= (op_q == OP_RD);
                    swr_q   <= (op_q == OP_WR);
                    swrl_q  <= (op_q == OP_WRL);
                    swrh_q  <= (op_q == OP_WRH);
                    state_q <= S_EXEC;
                end

                S_EXEC: begin
                    if (op_q == OP_RD) begin
                        state_q <= S_CAPT;
                    end else begin
                        // Writes complete without a capture cycle.
                        done_a_q <= ~owner_b_q;
                        done_b_q <= owner_b_q;
                        state_q  <= S_DONE;
                    end
                end

                S_CAPT: begin
                    // Register file output is valid now; RData only ever
                    // changes here, so writes leave it alone.
                    rdata_q  <= bus.SDataOut;
                    done_a_q <= ~owner_b_q;
                    done_b_q <= owner_b_q;
                    state_q  <= S_DONE;
                end

                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.SAddr   = saddr_q;
    assign bus.SDataIn = sdin_q;
    assign bus.SRD     = srd_q;
    assign bus.SWR     = swr_q;
    assign bus.SWR_l   = swrl_q;
    assign bus.SWR_h   = swrh_q;
    assign bus.DoneA   = done_a_q;
    assign bus.DoneB   = done_b_q;
    assign bus.RData   = rdata_q;
    assign bus.Busy    = busy_q;

endmodule

// File: tb/tb_sreg_arbiter.sv
// Bench for sreg_arbiter: a behavioural register file on the command port,
// a reference register image updated from the opcode rules, and
// transaction-level timing expectations taken from the cycle counts.
module tb_sreg_arbiter;

    logic Clk = 1'b0;
    logic Rst;

    sreg_arbiter_if #(.NREGS_LOG2(3), .DW(16)) bus ();

    sreg_arbiter #(.NREGS_LOG2(3), .DW(16)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] init_val(input int i);
        return 16'h1357 + 16'(i) * 16'h2221;
    endfunction

    // Behavioural register file: write strobes update storage, SRD loads the
    // registered read port one clock later.
    logic [15:0] rf [8];
    bit          rf_loaded = 1'b0;
    always @(posedge Clk) begin
        if (!rf_loaded) begin
            for (int i = 0; i < 8; i++) rf[i] <= init_val(i);
            rf_loaded <= 1'b1;
        end else begin
            if (bus.SRD)   bus.SDataOut        <= rf[bus.SAddr];
            if (bus.SWR)   rf[bus.SAddr]       <= bus.SDataIn;
            if (bus.SWR_l) rf[bus.SAddr][7:0]  <= bus.SDataIn[7:0];
            if (bus.SWR_h) rf[bus.SAddr][15:8] <= bus.SDataIn[15:8];
        end
    end

    // Always-on protocol checks: one strobe at a time, address/data frozen
    // for the whole busy window.
    logic        busy_prev = 1'b0;
    logic [2:0]  saddr_prev;
    logic [15:0] sdin_prev;
    always @(negedge Clk) begin
        chk("one_strobe", 32'({1'b0} + ($countones({bus.SRD, bus.SWR, bus.SWR_l, bus.SWR_h}) <= 1)), 32'd1);
        if (bus.Busy && busy_prev) begin
            chk("saddr_stable", 32'(bus.SAddr), 32'(saddr_prev));
            chk("sdin_stable", 32'(bus.SDataIn), 32'(sdin_prev));
        end
        busy_prev  <= bus.Busy;
        saddr_prev <= bus.SAddr;
        sdin_prev  <= bus.SDataIn;
    end

    // Reference model state
    logic [15:0] ref_rf [8];
    logic [15:0] exp_rd;
    bit          last_b;    // last-served side for round-robin ties

    task automatic model_apply(input logic [1:0] op, input logic [2:0] addr, input logic [15:0] wd);
        case (op)
            2'b00: exp_rd = ref_rf[addr];
            2'b01: ref_rf[addr] = wd;
            2'b10: ref_rf[addr] = {ref_rf[addr][15:8], wd[7:0]};
            default: ref_rf[addr] = {wd[15:8], ref_rf[addr][7:0]};
        endcase
    endtask

    // One transaction from a single port, entered just after a rising edge
    // in IDLE. Watches six cycles after the sampling edge.
    task automatic run_single(input bit port, input logic [1:0] op, input logic [2:0] addr,
                              input logic [15:0] wd, input bit perturb);
        int          nstrobe = 0, strobe_cyc = 0, done_cyc = 0, ndone_own = 0, ndone_oth = 0;
        logic [3:0]  kind = 4'b0, strobes;
        logic [2:0]  saddr_at = 3'b0;
        logic [15:0] sdin_at = 16'h0, rd_at_done = 16'h0;
        logic        own, oth;
        if (!port) begin
            bus.ReqA = 1'b1; bus.OpA = op; bus.AddrA = addr; bus.WDataA = wd;
        end else begin
            bus.ReqB = 1'b1; bus.OpB = op; bus.AddrB = addr; bus.WDataB = wd;
        end
        @(posedge Clk); #1;
        bus.ReqA = 1'b0; bus.ReqB = 1'b0;
        if (perturb) begin
            // late changes must not leak into the running transaction
            bus.AddrA = addr ^ 3'd1; bus.OpA = ~op; bus.WDataA = ~wd;
            bus.AddrB = addr ^ 3'd1; bus.OpB = ~op; bus.WDataB = ~wd;
        end
        model_apply(op, addr, wd);
        last_b = port;
        for (int k = 1; k <= 6; k++) begin
            @(negedge Clk);
            if (k == 1) chk("busy_in_setup", 32'(bus.Busy), 32'd1);
            strobes = {bus.SRD, bus.SWR, bus.SWR_l, bus.SWR_h};
            if (strobes != 4'b0) begin
                nstrobe++; strobe_cyc = k; kind = strobes; saddr_at = bus.SAddr; sdin_at = bus.SDataIn;
            end
            own = port ? bus.DoneB : bus.DoneA;
            oth = port ? bus.DoneA : bus.DoneB;
            if (own) begin ndone_own++; done_cyc = k; rd_at_done = bus.RData; end
            if (oth) ndone_oth++;
            if (k == 6) chk("busy_back_idle", 32'(bus.Busy), 32'd0);
            @(posedge Clk); #1;
        end
        chk("strobe_count", nstrobe, 1);
        chk("strobe_cycle", strobe_cyc, 2);
        chk("strobe_kind", 32'(kind), 32'(4'b1000 >> op));
        chk("strobe_saddr", 32'(saddr_at), 32'(addr));
        chk("strobe_sdin", 32'(sdin_at), 32'(wd));
        chk("done_count", ndone_own, 1);
        chk("done_cycle", done_cyc, (op == 2'b00) ? 4 : 3);
        chk("other_done", ndone_oth, 0);
        chk("rdata", 32'(rd_at_done), 32'(exp_rd));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          exp_b [4];
        bit          ptr;
        int          got;
        bit          got_b;
        logic [1:0]  rop;
        logic [2:0]  raddr;

        for (int i = 0; i < 8; i++) ref_rf[i] = init_val(i);
        exp_rd = 16'h0;
        last_b = 1'b1;
        bus.ReqA = 0; bus.ReqB = 0; bus.OpA = 0; bus.OpB = 0;
        bus.AddrA = 0; bus.AddrB = 0; bus.WDataA = 0; bus.WDataB = 0;

        // reset
        Rst = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_done", 32'({bus.DoneA, bus.DoneB}), 32'd0);
        chk("rst_strobes", 32'({bus.SRD, bus.SWR, bus.SWR_l, bus.SWR_h}), 32'd0);
        chk("rst_saddr", 32'(bus.SAddr), 32'd0);
        chk("rst_sdin", 32'(bus.SDataIn), 32'd0);
        chk("rst_rdata", 32'(bus.RData), 32'd0);
        @(posedge Clk); #1;
        Rst = 1'b0;

        // directed: A full write, B low-byte write, B read back
        run_single(1'b0, 2'b01, 3'd3, 16'habcd, 1'b0);
        run_single(1'b1, 2'b10, 3'd3, 16'h1234, 1'b0);
        run_single(1'b1, 2'b00, 3'd3, 16'h0000, 1'b0);
        chk("readback_ab34", 32'(exp_rd), 32'h0000ab34);

        // random single-port traffic
        for (int t = 0; t < 24; t++) begin
            rop   = 2'($urandom_range(0, 3));
            raddr = 3'($urandom_range(0, 7));
            run_single(1'($urandom_range(0, 1)), rop, raddr, 16'($urandom), 1'b0);
        end

        // both ports reading simultaneously
        ptr = last_b;
        for (int i = 0; i < 4; i++) begin
`ifdef SREG_ARB_RR_EN
            exp_b[i] = ~ptr;
            ptr = ~ptr;
`else
            exp_b[i] = 1'b0;
`endif
        end
        bus.ReqA = 1; bus.OpA = 2'b00; bus.AddrA = 3'd1;
        bus.ReqB = 1; bus.OpB = 2'b00; bus.AddrB = 3'd2;
        got = 0;
        for (int c = 0; c < 80 && got < 4; c++) begin
            @(negedge Clk);
            if (bus.DoneA || bus.DoneB) begin
                chk("tie_order", 32'(bus.DoneB), 32'(exp_b[got]));
                chk("tie_rdata", 32'(bus.RData), 32'(ref_rf[bus.DoneB ? 2 : 1]));
                got++;
                if (got == 4) bus.ReqA = 1'b0;
            end
        end
        chk("tie_count", got, 4);
        got_b = 1'b0;
        for (int c = 0; c < 20 && !got_b; c++) begin
            @(negedge Clk);
            chk("drop_a_no_done_a", 32'(bus.DoneA), 32'd0);
            if (bus.DoneB) begin
                got_b = 1'b1;
                bus.ReqB = 1'b0;
                chk("drop_a_rdata", 32'(bus.RData), 32'(ref_rf[2]));
            end
        end
        chk("drop_a_b_served", 32'(got_b), 32'd1);
        exp_rd = ref_rf[2];
        last_b = 1'b1;
        @(posedge Clk); #1;

        // late request changes are ignored
        run_single(1'b0, 2'b01, 3'd4, 16'h4b4b, 1'b0);
        run_single(1'b0, 2'b01, 3'd5, 16'h5a5a, 1'b0);
        run_single(1'b0, 2'b00, 3'd5, 16'h0000, 1'b1);
        chk("late_change_rdata", 32'(exp_rd), 32'h00005a5a);

        // reset during CAPT
        chk("pre_rst_rdata_nz", 32'(bus.RData != 16'h0), 32'd1);
        bus.ReqA = 1; bus.OpA = 2'b00; bus.AddrA = 3'd2;
        @(posedge Clk); #1;          // SETUP
        bus.ReqA = 0;
        @(posedge Clk); #1;          // EXEC
        @(posedge Clk); #1;          // CAPT
        chk("capt_busy", 32'(bus.Busy), 32'd1);
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(negedge Clk);
        chk("mid_rst_busy", 32'(bus.Busy), 32'd0);
        chk("mid_rst_rdata", 32'(bus.RData), 32'd0);
        chk("mid_rst_saddr", 32'(bus.SAddr), 32'd0);
        chk("mid_rst_done", 32'({bus.DoneA, bus.DoneB}), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            chk("post_rst_no_done", 32'({bus.DoneA, bus.DoneB}), 32'd0);
            chk("post_rst_idle", 32'(bus.Busy), 32'd0);
        end
        exp_rd = 16'h0;
        last_b = 1'b1;
        @(posedge Clk); #1;

        // recovery after reset
        run_single(1'b1, 2'b11, 3'd6, 16'hc3c3, 1'b0);
        run_single(1'b0, 2'b00, 3'd6, 16'h0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sreg_arbiter.md
# sreg_arbiter

Two-port arbiter and sequencer for the eight-entry 16-bit scalar register file. Two requesters share the register file's single command port. Port A is the execute stage; port B is the load/store unit. The block arbitrates between them, sequences the address-setup / command / capture cycles the register file needs, and returns read data with a one-cycle completion pulse. It sits between the pipeline and the scalar register file and is the only driver of that file's command and address inputs.

## Interface
- `NREGS_LOG2`, 3, width of the register address; register file depth is 2^NREGS_LOG2.
- `DW`, 16, data width.
- `Clk`  in  1  single system clock; all state changes on its rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `ReqA`, `ReqB`  in  1  transaction request, one per requester.
- `OpA`, `OpB`  in  2  operation code:
  - 00 = read
  - 01 = write
  - 10 = write low byte
  - 11 = write high byte
- `AddrA`, `AddrB`  in  NREGS_LOG2  register index.
- `WDataA`, `WDataB`  in  DW  write data.
- `DoneA`, `DoneB`  out  1  one-cycle completion pulse.
- `RData`  out  DW  read result; valid while the relevant Done is high, and held afterwards.
- `Busy`  out  1  high in every state except IDLE.
- `SAddr`  out  NREGS_LOG2  address to the register file.
- `SDataIn`  out  DW  write data to the register file.
- `SRD`, `SWR`, `SWR_l`, `SWR_h`  out  1  command strobes to the register file.
- `SDataOut`  in  DW  registered read data from the register file.

## Operation
- States are IDLE, SETUP, EXEC, CAPT and DONE.
- **IDLE**
  - If either Req is high, pick a winner.
  - Latch the winner's Op, Addr and WData, plus a 1-bit owner flag. Go to SETUP.
  - If neither Req is high, stay in IDLE.
- **SETUP**
  - SAddr and SDataIn are driven from the latched values; all strobes are 0.
  - Go to EXEC.
- **EXEC**
  - Exactly one strobe is high, decoded from the latched Op: 00→SRD, 01→SWR, 10→SWR_l, 11→SWR_h.
  - Reads go to CAPT; writes go to DONE.
- **CAPT**
  - Strobes are 0. At the end of this cycle, RData is loaded from SDataOut.
  - Go to DONE.
- **DONE**
  - The owner's Done is high for exactly this cycle.
  - Go to IDLE.
- SAddr and SDataIn hold the latched values from SETUP through DONE. They are never changed mid-transaction.
- At most one strobe is high in any cycle. Strobes are high only in EXEC.
- Req/Op/Addr/WData are sampled only in IDLE. Changes made later have no effect.
  - Dropping Req mid-transaction does not abort the transaction.
  - A Req still high in the IDLE cycle after Done is treated as a new request.
- The losing requester keeps Req high and is served on the next IDLE. No request is ever dropped.
- RData is only updated by reads. Writes leave RData unchanged.

## Timing
- Req is sampled high at edge n while in IDLE.
- Write: SETUP in cycle n+1, strobe in cycle n+2, Done in cycle n+3. Back-to-back writes take 4 cycles each.
- Read: SETUP in cycle n+1, SRD in cycle n+2, CAPT in cycle n+3, Done with RData valid in cycle n+4. Back-to-back reads take 5 cycles each.
- Reset values:
  - state = IDLE.
  - All strobes, DoneA, DoneB and Busy = 0.
  - SAddr = 0, SDataIn = 0, RData = 0.
  - Owner = A; round-robin last-served pointer = B, so A wins the first tie.
- Reset asserted mid-transaction:
  - The next cycle shows reset values.
  - The in-flight transaction is abandoned with no Done.
  - A strobe already issued is not retracted.

## Configuration
- `SREG_ARB_RR_EN` defined: round-robin arbitration.
  - On simultaneous ReqA and ReqB, the requester not served last wins.
  - The last-served pointer updates in IDLE when a winner is picked.
- `SREG_ARB_RR_EN` undefined: fixed priority.
  - A always wins a tie. B is served only when ReqA is low in IDLE.
  - The pointer logic is absent.

## Test plan
- Reset, then ReqA write 01 to Addr 3 with WData `16'habcd`:
  - SWR high only in cycle n+2, with SAddr = 3.
  - DoneA in cycle n+3. DoneB stays 0 and RData stays 0.
- ReqB write-low to Addr 3 with `16'h1234`, then ReqB read of Addr 3:
  - SWR_l high once.
  - Read returns RData = `16'habcd`→`16'hab34`, with DoneB in cycle n+4.
- ReqA and ReqB held simultaneously, each doing reads:
  - With `SREG_ARB_RR_EN`, Done alternates A,B,A,B.
  - Without it, B is never served while ReqA stays high; dropping ReqA lets B complete next.
- ReqA read issued, then ReqA dropped and AddrA changed during SETUP:
  - The transaction completes using the original address.
  - Exactly one SRD occurs.
- Rst asserted during CAPT:
  - The next cycle shows state IDLE, Busy = 0 and RData = 0.
  - No Done pulses.
- Over all scenarios, a checker asserts:
  - At most one strobe per cycle.
  - SAddr is stable from SETUP through DONE.
